hwa_frame_feeder: RTL and testbench
===================================

// Module: hwa_frame_feeder
// PURPOSE
//  Upstream stage of HWA_total. Accepts binary samples over a valid/ready stream, buffers them
//  in a small FIFO, presents each sample on the HWA input for exactly one stochastic frame
//  (2^N clocks), and pulses the HWA start on the first frame of a run. Marks the last frame cycle.
// PARAMETERS
//  N           12  sample width; frame length = 2^N cycles (4096)
//  FIFO_DEPTH  4   sample FIFO entries, power of 2, >=2
// PORTS
//  clock        in   1    single clock, all state on posedge
//  reset_n      in   1    asynchronous, active-low reset
//  enable       in   1    run request; sampled in IDLE and at frame boundaries
//  s_valid      in   1    upstream sample valid
//  s_data       in   N    upstream sample, unsigned binary
//  s_ready      out  1    FIFO not full
//  hwa_in       out  N    sample driven to HWA_total.in
//  hwa_start    out  1    one-cycle pulse, first cycle of a run's first frame
//  frame_last   out  1    high on final cycle (cnt==2^N-1) of every active frame
//  busy         out  1    state==RUN
//  underrun     out  1    sticky: a frame boundary found the FIFO empty
// BEHAVIOUR
//  Reset: hwa_in=0, hwa_start=0, cnt=0, state=IDLE, FIFO empty, underrun=0; s_ready=1 after reset.
//  Push: s_valid & s_ready. No bypass: a pushed sample is poppable the next cycle.
//  s_ready = !full only; push+pop in the same cycle on a full FIFO: pop happens, push refused.
//  FSM IDLE: if enable & !empty -> pop head; next cycle hwa_in=head, hwa_start=1, cnt=0, RUN.
//    Otherwise hold hwa_in (last value), hwa_start=0.
//  FSM RUN: cnt (N bits) increments every cycle, wraps 2^N-1 -> 0.
//    frame_last = busy & (cnt==2^N-1), combinational from registered cnt.
//    At cnt==2^N-1: enable & !empty -> pop; hwa_in updates on wrap; stay RUN; no hwa_start.
//      enable & empty -> underrun=1; hwa_in held (sample repeated), stay RUN (see CONFIGURATION).
//      !enable -> IDLE; hwa_in held; FIFO contents kept.
//  enable deasserted mid-frame: current frame always completes (no truncation).
//  Latency: IDLE pop to hwa_in valid = 1 cycle; each sample is on hwa_in for exactly 2^N cycles.
//  underrun clears only on reset_n. reset_n low mid-frame: immediate return to reset values.
// CONFIGURATION
//  HWA_FEED_STOP_ON_UNDERRUN_EN defined: underrun at boundary -> set underrun, go IDLE;
//    next run re-pulses hwa_start. Undefined: sample repeats, RUN continues (default).
// STRUCTURE
//  Package hwa_pkg: N, POW2N, FIFO_DEPTH defaults; typedef sample_t (logic [N-1:0]);
//    typedef enum feed_state_e {IDLE, RUN}.
//  Sub-module hwa_feed_fifo: sync FIFO, circular pointers with extra wrap bit, full/empty,
//    ports push/pop/din/dout/full/empty. Feeder = FSM + frame counter + output regs.
// TESTING
//  1 Push 3, 7; enable=1 -> hwa_start one cycle with hwa_in=3; hwa_in=7 exactly 4096 cycles later.
//  2 Fill 4 entries, hold s_valid -> s_ready=0, 5th sample not accepted; after one pop s_ready=1.
//  3 One sample, enable held -> at boundary underrun=1, hwa_in stays put, busy=1;
//    with HWA_FEED_STOP_ON_UNDERRUN_EN: busy=0, next push+enable gives new hwa_start.
//  4 Drop enable at cnt=100 -> frame runs to 4095, frame_last pulse, then busy=0, hwa_in held.
//  5 reset_n low at cnt=2000 -> all outputs to reset values same cycle; FIFO empty, s_ready=1.
//  6 Continuous stream 0x003,0x007,0x00B.. -> exactly one frame_last per 4096 cycles, no gaps.

Source files
------------

// File: rtl/hwa_pkg.sv
// Shared defaults and types for the HWA frame feeder.
// Optional build macro: HWA_FEED_STOP_ON_UNDERRUN_EN (see hwa_frame_feeder).
package hwa_pkg;

  localparam int unsigned N          = 12;
  localparam int unsigned POW2N      = 1 << N;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef logic [N-1:0] sample_t;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } feed_state_e;

endpackage

// File: rtl/hwa_feed_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers; no write-to-read bypass.
module hwa_feed_fifo #(
  parameter int unsigned W     = hwa_pkg::N,
  parameter int unsigned DEPTH = hwa_pkg::FIFO_DEPTH
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  import hwa_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A push on a full FIFO is refused even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hwa_frame_feeder.sv
// Feeds buffered samples to HWA_total, one sample per 2^N-cycle stochastic frame.
// Build option HWA_FEED_STOP_ON_UNDERRUN_EN: an empty FIFO at a frame boundary ends the run.
module hwa_frame_feeder #(
  parameter int unsigned N          = hwa_pkg::N,
  parameter int unsigned FIFO_DEPTH = hwa_pkg::FIFO_DEPTH
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic [N-1:0] hwa_in,
  output logic         hwa_start,
  output logic         frame_last,
  output logic         busy,
  output logic         underrun
);
  import hwa_pkg::*;

  localparam logic [N-1:0] CntMax = {N{1'b1}};

  feed_state_e  state_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] fifo_dout;
  logic         fifo_full, fifo_empty;
  logic         at_boundary, pop;

  assign at_boundary = (state_q == RUN) && (cnt_q == CntMax);
  assign pop         = enable & ~fifo_empty & ((state_q == IDLE) | at_boundary);
  assign s_ready     = ~fifo_full;
  assign busy        = (state_q == RUN);
  assign frame_last  = at_boundary;

  hwa_feed_fifo #(
    .W     (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (s_valid),
    .pop     (pop),
    .din     (s_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hwa_in    <= '0;
      hwa_start <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      hwa_start <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && !fifo_empty) begin
            hwa_in    <= fifo_dout;
            hwa_start <= 1'b1;
            cnt_q     <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntMax) begin
            if (enable && !fifo_empty) begin
              hwa_in <= fifo_dout;
            end else if (enable) begin
              // Starved: hwa_in keeps the previous sample.
              underrun <= 1'b1;
`ifdef HWA_FEED_STOP_ON_UNDERRUN_EN
              state_q  <= IDLE;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwa_frame_feeder.sv
// Directed self-checking bench for hwa_frame_feeder (N=12, 4096-cycle frames).
module tb_hwa_frame_feeder;

  localparam int unsigned N     = 12;
  localparam int unsigned Frame = 1 << N;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         s_valid;
  logic [N-1:0] s_data;
  logic         s_ready;
  logic [N-1:0] hwa_in;
  logic         hwa_start;
  logic         frame_last;
  logic         busy;
  logic         underrun;

  int checks   = 0;
  int failures = 0;

  hwa_frame_feeder #(
    .N          (N),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .hwa_in     (hwa_in),
    .hwa_start  (hwa_start),
    .frame_last (frame_last),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [N-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  logic [N-1:0] stream [4];
  int           fl_count;
  int           fl_misplaced;

  initial begin
    stream[0] = 12'h003;
    stream[1] = 12'h007;
    stream[2] = 12'h00B;
    stream[3] = 12'h00F;

    reset_n = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #22;
    check("rst_hwa_in", 32'(hwa_in), 32'h0);
    check("rst_start", 32'(hwa_start), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_s_ready", 32'(s_ready), 32'h1);
    check("rst_frame_last", 32'(frame_last), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    // Two samples, then a run: first frame 3, second frame 7, enable dropped mid-frame.
    push(12'h003);
    push(12'h007);
    check("idle_no_start", 32'(busy), 32'h0);
    enable = 1'b1;
    tick();
    check("t1_start", 32'(hwa_start), 32'h1);
    check("t1_first_in", 32'(hwa_in), 32'h003);
    tick();
    check("t1_start_pulse", 32'(hwa_start), 32'h0);
    tick(Frame - 2);
    check("t1_last_cycle", 32'(frame_last), 32'h1);
    check("t1_in_held", 32'(hwa_in), 32'h003);
    tick();
    check("t1_second_in", 32'(hwa_in), 32'h007);
    check("t1_no_restart", 32'(hwa_start), 32'h0);
    check("t1_fl_clear", 32'(frame_last), 32'h0);
    tick(100);
    enable = 1'b0;
    tick(Frame - 101);
    check("t4_frame_completes", 32'(frame_last), 32'h1);
    check("t4_busy_to_end", 32'(busy), 32'h1);
    tick();
    check("t4_idle", 32'(busy), 32'h0);
    check("t4_in_held", 32'(hwa_in), 32'h007);
    check("t4_no_underrun", 32'(underrun), 32'h0);
    tick(3);
    check("t4_in_still_held", 32'(hwa_in), 32'h007);

    // Fill the FIFO; a 5th sample held on s_valid must be refused.
    for (int i = 0; i < 4; i++) push(stream[i]);
    s_valid = 1'b1;
    s_data  = 12'h013;
    #1;
    check("t2_full", 32'(s_ready), 32'h0);
    tick();
    check("t2_still_full", 32'(s_ready), 32'h0);
    enable = 1'b1;
    tick();
    check("t2_pop_start", 32'(hwa_start), 32'h1);
    check("t2_ready_after_pop", 32'(s_ready), 32'h1);
    s_valid = 1'b0;

    // Back-to-back frames: one frame_last per frame on its final cycle only.
    fl_count     = 0;
    fl_misplaced = 0;
    for (int f = 0; f < 4; f++) begin
      check($sformatf("t6_frame%0d_in", f), 32'(hwa_in), 32'(stream[f]));
      check($sformatf("t6_frame%0d_underrun", f), 32'(underrun), 32'h0);
      for (int i = 0; i < int'(Frame); i++) begin
        if (frame_last) begin
          fl_count++;
          if (i != int'(Frame) - 1) fl_misplaced++;
        end
        tick();
      end
    end
    check("t6_fl_count", 32'(fl_count), 32'd4);
    check("t6_fl_misplaced", 32'(fl_misplaced), 32'd0);

    // Boundary with an empty FIFO: 0x013 was never accepted, so this is an underrun.
    check("t3_underrun", 32'(underrun), 32'h1);
    check("t3_in_held", 32'(hwa_in), 32'h00F);
`ifdef HWA_FEED_STOP_ON_UNDERRUN_EN
    check("t3_stopped", 32'(busy), 32'h0);
    push(12'h0AA);
    check("t3_no_early_start", 32'(hwa_start), 32'h0);
    tick();
    check("t3_restart", 32'(hwa_start), 32'h1);
    check("t3_restart_in", 32'(hwa_in), 32'h0AA);
`else
    check("t3_still_busy", 32'(busy), 32'h1);
    check("t3_no_start", 32'(hwa_start), 32'h0);
`endif

    // Reset mid-frame at cnt=2000 with a sample still queued.
    push(12'h0BB);
    tick(1999);
    check("t5_pre_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("t5_hwa_in", 32'(hwa_in), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_underrun", 32'(underrun), 32'h0);
    check("t5_start", 32'(hwa_start), 32'h0);
    check("t5_frame_last", 32'(frame_last), 32'h0);
    check("t5_s_ready", 32'(s_ready), 32'h1);
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    enable = 1'b1;
    tick(2);
    check("t5_fifo_empty", 32'(busy), 32'h0);
    check("t5_in_zero", 32'(hwa_in), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
